fft_engine_ctrl: RTL and testbench

FFT_ENGINE_CTRL -- requirements
Module: fft_engine_ctrl

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/fft_butterfly.sv | 64 ++++++
 rtl/fft_engine_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fft_engine_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT engine.
//   state_e    - controller state encoding (IDLE, LOAD, CALC, GAP, UNLOAD)
//   twiddle_t  - Q15 complex twiddle factor
//   TW_QCOS    - first-quadrant Q15 cosine table, cos(2*pi*k/64), k = 0..16
//   tw_lookup  - W_64^k = (cos, -sin) for k = 0..31, built from TW_QCOS
//   bitrev     - reverse the low 'bits' bits of a 6-bit index
package fft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CALC,
      ST_GAP,
      ST_UNLOAD
   } state_e;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } twiddle_t;

   // One quadrant of a 64-point table. Any supported length (4..64) divides 64,
   // so every twiddle is an entry of this table at a scaled index.
   localparam logic signed [15:0] TW_QCOS [0:16] = '{
      16'sd32767, 16'sd32609, 16'sd32137, 16'sd31356, 16'sd30273, 16'sd28898,
      16'sd27245, 16'sd25329, 16'sd23170, 16'sd20787, 16'sd18204, 16'sd15446,
      16'sd12539, 16'sd9512,  16'sd6393,  16'sd3212,  16'sd0
   };

   // k covers angles [0, pi); sin is non-negative there, so imag = -table.
   function automatic twiddle_t tw_lookup(input logic [4:0] k);
      twiddle_t   w;
      logic [4:0] kc;
      logic [4:0] ks;
      kc   = (k <= 5'd16) ? k : 5'd0 - k;             // 32-k in the 2nd quadrant
      ks   = (k <= 5'd16) ? 5'd16 - k : k - 5'd16;
      w.re = (k <= 5'd16) ? TW_QCOS[kc] : -TW_QCOS[kc];
      w.im = -TW_QCOS[ks];
      return w;
   endfunction

   function automatic logic [5:0] bitrev(input logic [5:0] v, input int bits);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < 6; i++)
         if (i < bits) r[3'(i)] = v[3'(bits - 1 - i)];
      return r;
   endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly, one registered stage, result halved.
//   x = (a + b*w) / 2,  y = (a - b*w) / 2
//   clk, rst_n          - clock, async active-low reset
//   a_*_i, b_*_i        - DATA_WIDTH signed operands
//   w_re_i, w_im_i      - Q15 twiddle
//   x_*_o, y_*_o        - registered results, valid one cycle after the operands
module fft_butterfly #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] a_re_i,
   input  logic signed [DATA_WIDTH-1:0] a_im_i,
   input  logic signed [DATA_WIDTH-1:0] b_re_i,
   input  logic signed [DATA_WIDTH-1:0] b_im_i,
   input  logic signed [15:0]           w_re_i,
   input  logic signed [15:0]           w_im_i,
   output logic signed [DATA_WIDTH-1:0] x_re_o,
   output logic signed [DATA_WIDTH-1:0] x_im_o,
   output logic signed [DATA_WIDTH-1:0] y_re_o,
   output logic signed [DATA_WIDTH-1:0] y_im_o
);

   localparam int PW = DATA_WIDTH + 17;
   localparam int SW = DATA_WIDTH + 2;
   localparam logic signed [PW-1:0] RND = PW'(16384);

   logic signed [PW-1:0] br, bi, wr, wi, pr, pi;
   logic signed [SW-1:0] tr, ti, ar, ai, sxr, sxi, syr, syi;

   always_comb begin
      br  = PW'(b_re_i);
      bi  = PW'(b_im_i);
      wr  = PW'(w_re_i);
      wi  = PW'(w_im_i);
      // Q15 product, rounded to nearest so a unit twiddle passes b unchanged
      pr  = br * wr - bi * wi + RND;
      pi  = br * wi + bi * wr + RND;
      tr  = SW'(pr >>> 15);
      ti  = SW'(pi >>> 15);
      ar  = SW'(a_re_i);
      ai  = SW'(a_im_i);
      sxr = ar + tr;
      sxi = ai + ti;
      syr = ar - tr;
      syi = ai - ti;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_re_o <= '0;
         x_im_o <= '0;
         y_re_o <= '0;
         y_im_o <= '0;
      end else begin
         // per-stage halving keeps the full transform inside the sample range
         x_re_o <= DATA_WIDTH'(sxr >>> 1);
         x_im_o <= DATA_WIDTH'(sxi >>> 1);
         y_re_o <= DATA_WIDTH'(syr >>> 1);
         y_im_o <= DATA_WIDTH'(syi >>> 1);
      end
   end

endmodule

// File: rtl/fft_engine_ctrl.sv
// fft_engine_ctrl: in-place radix-2 DIT FFT with streaming load/unload.
// Output is DFT/POINTS (each of the log2(POINTS) stages halves).
//   clk, rst_n                   - clock, async active-low reset
//   inverse_i                    - only with FFT_INVERSE_EN: 1 = inverse transform,
//                                  captured on the first sample of a frame
//   in_valid_i/in_ready_o        - time-domain sample handshake, natural order
//   in_real_i, in_imag_i         - sample
//   out_valid_o/out_ready_i      - frequency bin handshake, k = 0..POINTS-1
//   out_real_o, out_imag_o       - bin value, out_last_o marks bin POINTS-1
//   busy_o                       - controller not idle
// Build option: define FFT_INVERSE_EN to add the inverse_i port.
module fft_engine_ctrl
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int POINTS     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef FFT_INVERSE_EN
   input  logic                         inverse_i,
`endif
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic signed [DATA_WIDTH-1:0] in_real_i,
   input  logic signed [DATA_WIDTH-1:0] in_imag_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic signed [DATA_WIDTH-1:0] out_real_o,
   output logic signed [DATA_WIDTH-1:0] out_imag_o,
   output logic                         out_last_o,
   output logic                         busy_o
);

   localparam int LW   = $clog2(POINTS);
   localparam int HALF = POINTS / 2;

   state_e                  state_q;
   logic [LW-1:0]           cnt_q;      // sample / butterfly / bin index
   logic [2:0]              stage_q;
   logic                    in_ready_q, out_valid_q, out_last_q, busy_q;
`ifdef FFT_INVERSE_EN
   logic                    inv_q;
`endif

   logic signed [DATA_WIDTH-1:0] mem_re_q [POINTS];
   logic signed [DATA_WIDTH-1:0] mem_im_q [POINTS];

   logic                    accept;
   logic [5:0]              b6, mask6, j6, ia6, ib6, k6, brv6;
   logic [LW-1:0]           ia, ib, wr_idx;
   twiddle_t                tw;
   logic signed [15:0]      tw_im;
   logic                    wb_vld_q;
   logic [LW-1:0]           wb_ia_q, wb_ib_q;
   logic signed [DATA_WIDTH-1:0] x_re, x_im, y_re, y_im;

   assign accept = in_valid_i && in_ready_q;

   // Butterfly b of stage s: span = 2^s, j = b mod span,
   // i = (b / span) * 2*span + j, twiddle W_64^(j * 2^(5-s)).
   always_comb begin
      b6     = 6'(cnt_q);
      mask6  = (6'd1 << stage_q) - 6'd1;
      j6     = b6 & mask6;
      ia6    = ((b6 >> stage_q) << (stage_q + 3'd1)) | j6;
      ib6    = ia6 | (6'd1 << stage_q);
      k6     = j6 << (3'd5 - stage_q);
      brv6   = bitrev(6'(cnt_q), LW);
      ia     = LW'(ia6);
      ib     = LW'(ib6);
      wr_idx = LW'(brv6);
      tw     = tw_lookup(5'(k6));
`ifdef FFT_INVERSE_EN
      tw_im  = inv_q ? -tw.im : tw.im;
`else
      tw_im  = tw.im;
`endif
   end

   fft_butterfly #(.DATA_WIDTH(DATA_WIDTH)) u_bfly (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_re_i (mem_re_q[ia]),
      .a_im_i (mem_im_q[ia]),
      .b_re_i (mem_re_q[ib]),
      .b_im_i (mem_im_q[ib]),
      .w_re_i (tw.re),
      .w_im_i (tw_im),
      .x_re_o (x_re),
      .x_im_o (x_im),
      .y_re_o (y_re),
      .y_im_o (y_im)
   );

   // Write-back addresses follow the butterfly's one-cycle latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_vld_q <= 1'b0;
         wb_ia_q  <= '0;
         wb_ib_q  <= '0;
      end else begin
         wb_vld_q <= (state_q == ST_CALC);
         wb_ia_q  <= ia;
         wb_ib_q  <= ib;
      end
   end

   // Working buffer: loaded in bit-reversed order, updated in place.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_re_q[wr_idx] <= in_real_i;
         mem_im_q[wr_idx] <= in_imag_i;
      end
      if (wb_vld_q) begin
         mem_re_q[wb_ia_q] <= x_re;
         mem_im_q[wb_ia_q] <= x_im;
         mem_re_q[wb_ib_q] <= y_re;
         mem_im_q[wb_ib_q] <= y_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         stage_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef FFT_INVERSE_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  state_q <= ST_LOAD;
                  cnt_q   <= LW'(1);
                  busy_q  <= 1'b1;
`ifdef FFT_INVERSE_EN
                  inv_q   <= inverse_i;
`endif
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  if (cnt_q == LW'(POINTS - 1)) begin
                     state_q    <= ST_CALC;
                     cnt_q      <= '0;
                     stage_q    <= '0;
                     in_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_CALC: begin
               if (cnt_q == LW'(HALF - 1)) begin
                  state_q <= ST_GAP;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Lets the stage's last write-back land before the next stage reads.
            ST_GAP: begin
               if (stage_q == 3'(LW - 1)) begin
                  state_q     <= ST_UNLOAD;
                  out_valid_q <= 1'b1;
               end else begin
                  stage_q <= stage_q + 3'd1;
                  state_q <= ST_CALC;
               end
            end
            ST_UNLOAD: begin
               if (out_ready_i) begin
                  if (cnt_q == LW'(POINTS - 1)) begin
                     state_q     <= ST_IDLE;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     out_last_q <= (cnt_q == LW'(POINTS - 2));
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = busy_q;
   // Buffer is static during UNLOAD, so the bin holds while stalled.
   assign out_real_o  = out_valid_q ? mem_re_q[cnt_q] : '0;
   assign out_imag_o  = out_valid_q ? mem_im_q[cnt_q] : '0;

endmodule

// File: tb/tb_fft_engine_ctrl.sv
module tb_fft_engine_ctrl;
   localparam int DW = 16;
   localparam int N  = 16;
   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_last_o, busy_o;
   logic signed [DW-1:0] in_real_i, in_imag_i, out_real_o, out_imag_o;
`ifdef FFT_INVERSE_EN
   logic inverse_i;
`endif

   fft_engine_ctrl #(.DATA_WIDTH(DW), .POINTS(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef FFT_INVERSE_EN
      .inverse_i   (inverse_i),
`endif
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_real_i   (in_real_i),
      .in_imag_i   (in_imag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_real_o  (out_real_o),
      .out_imag_o  (out_imag_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int fr_re [N], fr_im [N];
   int got_re[N], got_im[N];
   int ex_re [N], ex_im [N];

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      n_chk++;
      if (obs > exp + tol || obs < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // Reference: direct DFT scaled by 1/N (conjugate kernel for inverse).
   task automatic model(input bit inv);
      for (int k = 0; k < N; k++) begin
         real sr, si, ang, c, s;
         sr = 0.0; si = 0.0;
         for (int n = 0; n < N; n++) begin
            ang = 2.0 * PI * real'(n * k) / real'(N);
            c = $cos(ang);
            s = inv ? -$sin(ang) : $sin(ang);
            sr += real'(fr_re[n]) * c + real'(fr_im[n]) * s;
            si += real'(fr_im[n]) * c - real'(fr_re[n]) * s;
         end
         ex_re[k] = rnd(sr / real'(N));
         ex_im[k] = rnd(si / real'(N));
      end
   endtask

   // Entered and left on a falling edge.
   task automatic send_frame(input bit gaps);
      int n = 0;
      int guard = 0;
      bit acc;
      while (n < N && guard < 2000) begin
         in_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_real_i  = DW'(fr_re[n]);
         in_imag_i  = DW'(fr_im[n]);
         acc = in_valid_i && in_ready_o;
         @(negedge clk);
         if (acc) n++;
         guard++;
      end
      in_valid_i = 1'b0;
      check("send_to", n, N);
   endtask

   // mode 0: out_ready toggles 1/0, mode 1: random out_ready.
   task automatic recv_frame(input int mode);
      int k = 0;
      int guard = 0;
      bit stall = 0;
      int hre = 0;
      int hlast = 0;
      while (k < N && guard < 2000) begin
         out_ready_i = (mode == 0) ? (guard % 2 == 0) : ($urandom_range(0, 1) == 1);
         if (out_valid_o) begin
            if (stall) begin
               check("hold_re", out_real_o, hre);
               check("hold_last", int'(out_last_o), hlast);
            end
            if (out_ready_i) begin
               got_re[k] = out_real_o;
               got_im[k] = out_imag_o;
               check($sformatf("last[%0d]", k), int'(out_last_o), (k == N - 1) ? 1 : 0);
               k++;
               stall = 0;
            end else begin
               stall = 1;
               hre   = out_real_o;
               hlast = int'(out_last_o);
            end
         end
         @(negedge clk);
         guard++;
      end
      out_ready_i = 1'b0;
      check("recv_to", k, N);
      check("idle_busy", int'(busy_o), 0);
      check("idle_ovalid", int'(out_valid_o), 0);
   endtask

   task automatic cmp_frame(input string tag, input int tol);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_re[%0d]", tag, k), got_re[k], ex_re[k], tol);
         check($sformatf("%s_im[%0d]", tag, k), got_im[k], ex_im[k], tol);
      end
   endtask

   task automatic set_impulse();
      for (int n = 0; n < N; n++) begin fr_re[n] = 0; fr_im[n] = 0; end
      fr_re[0] = 16384;
      for (int k = 0; k < N; k++) begin ex_re[k] = 1024; ex_im[k] = 0; end
   endtask

   initial begin
      int cyc, low;
      rst_n = 1'b0;
      in_valid_i = 1'b0; in_real_i = '0; in_imag_i = '0; out_ready_i = 1'b0;
`ifdef FFT_INVERSE_EN
      inverse_i = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready_o), 0);
      check("rst_out_valid", int'(out_valid_o), 0);
      check("rst_out_last", int'(out_last_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_out_real", out_real_o, 0);
      check("rst_out_imag", out_imag_o, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_ready", int'(in_ready_o), 1);

      // impulse, back-to-back input, timing, toggling out_ready
      set_impulse();
      send_frame(0);
      check("calc_busy", int'(busy_o), 1);
      cyc = 0; low = 0;
      while (!out_valid_o && cyc < 200) begin
         if (!in_ready_o) low++;
         cyc++;
         @(negedge clk);
      end
      check("calc_cycles", cyc, 36);
      check("ready_low", low, 36);
      recv_frame(0);
      cmp_frame("imp", 1);

      // DC
      for (int n = 0; n < N; n++) begin fr_re[n] = 16384; fr_im[n] = 0; end
      send_frame(1);
      recv_frame(1);
      for (int k = 0; k < N; k++) begin
         check($sformatf("dc_re[%0d]", k), got_re[k], (k == 0) ? 16384 : 0, (k == 0) ? 2 : 1);
         check($sformatf("dc_im[%0d]", k), got_im[k], 0, 1);
      end

      // cosine at bin 1
      for (int n = 0; n < N; n++) begin
         fr_re[n] = rnd(16384.0 * $cos(2.0 * PI * real'(n) / real'(N)));
         fr_im[n] = 0;
      end
      send_frame(1);
      recv_frame(0);
      for (int k = 0; k < N; k++) begin
         ex_re[k] = (k == 1 || k == N - 1) ? 8192 : 0;
         ex_im[k] = 0;
      end
      cmp_frame("cos", 2);

      // random frames against the DFT model
      for (int f = 0; f < 4; f++) begin
         for (int n = 0; n < N; n++) begin
            fr_re[n] = int'($urandom_range(0, 16383)) - 8192;
            fr_im[n] = int'($urandom_range(0, 16383)) - 8192;
         end
         model(0);
         send_frame(1);
         recv_frame(1);
         cmp_frame($sformatf("rnd%0d", f), 3);
      end

      // reset during CALC, then a clean frame
      for (int n = 0; n < N; n++) begin
         fr_re[n] = int'($urandom_range(0, 16383)) - 8192;
         fr_im[n] = 0;
      end
      send_frame(0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_ovalid", int'(out_valid_o), 0);
      check("midrst_ready", int'(in_ready_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      set_impulse();
      send_frame(1);
      recv_frame(1);
      cmp_frame("imp2", 1);

`ifdef FFT_INVERSE_EN
      // inverse of the impulse spectrum returns the scaled impulse
      for (int n = 0; n < N; n++) begin fr_re[n] = 1024; fr_im[n] = 0; end
      model(1);
      inverse_i = 1'b1;
      send_frame(0);
      inverse_i = 1'b0;
      recv_frame(1);
      cmp_frame("inv", 1);
      // a following forward frame must not inherit the inverse setting
      set_impulse();
      send_frame(0);
      recv_frame(0);
      cmp_frame("fwd_after_inv", 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
